mem_arbiter: RTL and testbench

//   Shares the single word-wide memory port (program memory / RAM / IO decode) between
//   the core's instruction-fetch port (read-only) and its load/store port.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one word-wide memory port between the core's instruction-fetch port
//   (read-only) and its load/store port. A granted request is registered, one
//   memory access cycle follows, and a registered response is returned two
//   cycles after the grant. Accesses the decoded region cannot perform are
//   faulted instead of executed.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | arbitrate between i_req/d_req, ack and latch the winner
//   ACCESS | drive the latched request to memory, capture the response
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   i_req/i_addr/i_ack                 fetch request handshake
//   i_rvalid/i_rdata/i_err             fetch response
//   d_req/d_addr/d_we/d_wdata/d_ack    load/store request handshake
//   d_rvalid/d_rdata/d_err             load/store response
//   mem_address/mem_in/mem_we          to memory
//   mem_out/mem_rcap/mem_wcap          from memory (combinational decode)
module mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic        i_ack,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [29:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [29:0] mem_address,
    output logic [31:0] mem_in,
    output logic        mem_we,
    input  logic [31:0] mem_out,
    input  logic        mem_rcap,
    input  logic        mem_wcap
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_nxt;
    logic        prio;        // 1 = data port wins under contention
    logic        lat_we;
    logic        lat_src;     // 1 = data port owns the access
    logic        grant_i, grant_d;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Grants are suppressed while reset is asserted so a requester never sees
    // an ack for a request the registers are about to drop.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    if (d_req && (!i_req || prio))
                        grant_d = 1'b1;
                    else if (i_req)
                        grant_i = 1'b1;
                    if (grant_d || grant_i)
                        state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign i_ack  = grant_i;
    assign d_ack  = grant_d;

    // rst_n in the product kills a write already in flight when reset lands
    // during ACCESS; the synchronous reset alone would be one edge too late.
    assign mem_we = (state == ACCESS) && lat_we && mem_wcap && rst_n;

    always_comb begin
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        if (lat_we) begin
            rsp_err = !mem_wcap;
        end else begin
            rsp_err   = !mem_rcap;
            rsp_rdata = mem_rcap ? mem_out : 32'h0;
        end
    end

    // mem_address/mem_in double as the latched request: they load at grant,
    // are valid through ACCESS and hold afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= DATA_FIRST;
            lat_we      <= 1'b0;
            lat_src     <= 1'b0;
            mem_address <= 30'h0;
            mem_in      <= 32'h0;
            i_rvalid    <= 1'b0;
            i_rdata     <= 32'h0;
            i_err       <= 1'b0;
            d_rvalid    <= 1'b0;
            d_rdata     <= 32'h0;
            d_err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (grant_d) begin
                prio        <= 1'b0;
                mem_address <= d_addr;
                mem_in      <= d_wdata;
                lat_we      <= d_we;
                lat_src     <= 1'b1;
            end else if (grant_i) begin
                prio        <= 1'b1;
                mem_address <= i_addr;
                lat_we      <= 1'b0;
                lat_src     <= 1'b0;
            end
            if (state == ACCESS) begin
                if (lat_src) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= rsp_rdata;
                    d_err    <= rsp_err;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= rsp_rdata;
                    i_err    <= rsp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter with a small region-decoded memory: program memory
//   (read only), unmapped, RAM (read/write) and IO (write only), selected by
//   word-address bits [29:28]. Expected responses are queued when an access
//   reaches memory and compared when the DUT returns them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [29:0] i_addr = '0;
    logic        i_ack, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [29:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [29:0] mem_address;
    logic [31:0] mem_in;
    logic        mem_we;
    logic [31:0] mem_out;
    logic        mem_rcap, mem_wcap;

    mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_in(mem_in), .mem_we(mem_we),
        .mem_out(mem_out), .mem_rcap(mem_rcap), .mem_wcap(mem_wcap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] prog    [0:15];
    logic [31:0] ram     [0:15];
    logic [31:0] ref_ram [0:15];

    function automatic bit rcap_of(input logic [29:0] a);
        return (a[29:28] == 2'b00) || (a[29:28] == 2'b10);
    endfunction

    function automatic bit wcap_of(input logic [29:0] a);
        return (a[29:28] == 2'b10) || (a[29:28] == 2'b11);
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] a);
        if (a[29:28] == 2'b00) return prog[a[3:0]];
        if (a[29:28] == 2'b10) return ref_ram[a[3:0]];
        return 32'h0;
    endfunction

    assign mem_rcap = rcap_of(mem_address);
    assign mem_wcap = wcap_of(mem_address);
    assign mem_out  = (mem_address[29:28] == 2'b00) ? prog[mem_address[3:0]] :
                      (mem_address[29:28] == 2'b10) ? ram[mem_address[3:0]]  : 32'h0;

    always @(posedge clk)
        if (mem_we && mem_address[29:28] == 2'b10)
            ram[mem_address[3:0]] <= mem_in;

    initial begin
        for (int k = 0; k < 16; k++) begin
            prog[k]    = 32'h01010101 * k;
            ram[k]     = 32'h0;
            ref_ram[k] = 32'h0;
        end
        prog[4] = 32'hDEADBEEF;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          src;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    bit          acc_pend = 1'b0;
    bit          acc_src;
    bit          acc_we;
    logic [29:0] acc_addr;
    logic [31:0] acc_wdata;

    always @(negedge clk) begin
        if (i_rvalid || d_rvalid) begin
            chk("one_rvalid", {31'h0, i_rvalid & d_rvalid}, 32'h0);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", {31'h0, d_rvalid}, {31'h0, e.src});
                chk("rsp_latency", cyc, e.cyc);
                if (d_rvalid) begin
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", {31'h0, d_err}, {31'h0, e.err});
                end else begin
                    chk("i_rdata", i_rdata, e.rdata);
                    chk("i_err", {31'h0, i_err}, {31'h0, e.err});
                end
            end
        end

        if (acc_pend) begin
            chk("mem_address", {2'b0, mem_address}, {2'b0, acc_addr});
            chk("mem_we_access", {31'h0, mem_we},
                {31'h0, acc_we & wcap_of(acc_addr) & rst_n});
            if (acc_we) chk("mem_in", mem_in, acc_wdata);
            if (rst_n) begin
                e.src = acc_src;
                e.cyc = cyc + 1;
                if (acc_we) begin
                    e.rdata = 32'h0;
                    e.err   = !wcap_of(acc_addr);
                    if (wcap_of(acc_addr) && acc_addr[29:28] == 2'b10)
                        ref_ram[acc_addr[3:0]] = acc_wdata;
                end else begin
                    e.err   = !rcap_of(acc_addr);
                    e.rdata = rcap_of(acc_addr) ? ref_read(acc_addr) : 32'h0;
                end
                sb.push_back(e);
            end
            acc_pend = 1'b0;
        end else begin
            chk("mem_we_idle", {31'h0, mem_we}, 32'h0);
        end

        if (i_ack || d_ack) begin
            chk("one_ack", {31'h0, i_ack & d_ack}, 32'h0);
            acc_pend = 1'b1;
            if (d_ack) begin
                acc_src = 1'b1; acc_we = d_we; acc_addr = d_addr; acc_wdata = d_wdata;
            end else begin
                acc_src = 1'b0; acc_we = 1'b0; acc_addr = i_addr; acc_wdata = 32'h0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ack(input bit data_port);
        int n = 0;
        forever begin
            @(negedge clk);
            if (data_port ? d_ack : i_ack) break;
            n++;
            if (n > 50) begin
                chk("ack_timeout", 32'h1, 32'h0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && !acc_pend) break;
            n++;
            if (n > 20) begin
                chk("drain_timeout", sb.size(), 32'h0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_fetch(input logic [31:0] baddr);
        i_addr = baddr[31:2];
        i_req  = 1'b1;
        wait_ack(1'b0);
        i_req  = 1'b0;
        drain();
    endtask

    task automatic do_data(input logic [31:0] baddr, input bit we, input logic [31:0] wd);
        d_addr  = baddr[31:2];
        d_we    = we;
        d_wdata = wd;
        d_req   = 1'b1;
        wait_ack(1'b1);
        d_req   = 1'b0;
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_i_rvalid"}, {31'h0, i_rvalid}, 32'h0);
        chk({tag, "_i_rdata"}, i_rdata, 32'h0);
        chk({tag, "_i_err"}, {31'h0, i_err}, 32'h0);
        chk({tag, "_d_rvalid"}, {31'h0, d_rvalid}, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_d_err"}, {31'h0, d_err}, 32'h0);
        chk({tag, "_mem_address"}, {2'b0, mem_address}, 32'h0);
        chk({tag, "_mem_in"}, mem_in, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        acc_pend = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
    endtask

    logic [1:0] pat [0:7];

    initial begin
        do_reset();

        // fetch from program memory
        do_fetch(32'h0000_0010);

        // RAM write then readback
        do_data(32'h8000_0020, 1'b1, 32'h1234_5678);
        do_data(32'h8000_0020, 1'b0, 32'h0);

        // contention from reset: D, I, D, I with one ack every two cycles
        do_reset();
        i_addr = 30'h4;
        d_addr = 30'h2000_0008;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat[k] = {d_ack, i_ack};
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 8; k++)
            chk($sformatf("contention_ack_%0d", k), {30'h0, pat[k]},
                (k % 4 == 0) ? 32'h2 : (k % 4 == 2) ? 32'h1 : 32'h0);
        drain();

        // faults: write to progmem, read IO, fetch unmapped
        do_data(32'h0000_0000, 1'b1, 32'hFFFF_FFFF);
        do_data(32'hFFFF_0000, 1'b0, 32'h0);
        do_fetch(32'h4000_0000);
        do_fetch(32'h0000_0014);

        // reset during ACCESS of a RAM write
        d_addr  = 30'h2000_0008;
        d_we    = 1'b1;
        d_wdata = 32'hCAFE_F00D;
        d_req   = 1'b1;
        wait_ack(1'b1);
        rst_n = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk("rst_access_mem_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        do_data(32'h8000_0020, 1'b0, 32'h0);
        chk("ram_word_kept", ram[8], 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
